// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: state encoding and status widths.
package pll_sup_pkg;
  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Supervisor <-> PLL/system bundle. Status signals exist only with PLL_SUP_STATUS_EN.
interface pll_sup_if;
  import pll_sup_pkg::*;
  logic locked;
  logic restart;
  logic pll_areset;
  logic sys_rst_n;
  logic fault;
  logic lock_loss;
`ifdef PLL_SUP_STATUS_EN
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;
  logic [STATE_W-1:0]    state_o;
`endif

  modport master (
    input  locked, restart,
`ifdef PLL_SUP_STATUS_EN
    output lock_loss_cnt, state_o,
`endif
    output pll_areset, sys_rst_n, fault, lock_loss
  );

  modport slave (
    output locked, restart,
`ifdef PLL_SUP_STATUS_EN
    input  lock_loss_cnt, state_o,
`endif
    input  pll_areset, sys_rst_n, fault, lock_loss
  );
endinterface

// File: rtl/pll_lock_supervisor_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: resets the PLL, waits for a stable lock, then releases sys_rst_n.
// Optional status outputs (loss counter, state) under `PLL_SUP_STATUS_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 4,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES     = 64,
  parameter int MAX_RETRIES        = 3
) (
  input logic      clk,
  input logic      rst,
  pll_sup_if.master bus
);
  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [RTY_W-1:0]   rty, rty_nx;
  logic               loss_nx;
  logic               lock_s;
  logic               pll_areset_q, sys_rst_n_q, fault_q, lock_loss_q;

  sync2 u_sync (.clk(clk), .rst(rst), .d(bus.locked), .q(lock_s));

  always_comb begin
    state_nx = state;
    rty_nx   = rty;
    loss_nx  = 1'b0;
    // Counter saturates rather than wrapping while parked in RUN/FAULT.
    cnt_nx   = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + 1'b1;
    if (bus.restart) begin
      state_nx = RST_PLL;
      rty_nx   = '0;
    end else begin
      case (state)
        RST_PLL:
          if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_nx = WAIT_LOCK;
        WAIT_LOCK:
          if (lock_s) state_nx = STABLE;
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (rty == RTY_W'(MAX_RETRIES)) state_nx = FAULT;
            else begin
              rty_nx   = rty + 1'b1;
              state_nx = RST_PLL;
            end
          end
        STABLE:
          if (!lock_s) state_nx = WAIT_LOCK;
          else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_nx = RUN;
            rty_nx   = '0;
          end
        RUN:
          if (!lock_s) begin
            state_nx = RST_PLL;
            loss_nx  = 1'b1;
          end
        FAULT: ;
        default: state_nx = RST_PLL;
      endcase
    end
    if (bus.restart || (state_nx != state)) cnt_nx = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RST_PLL;
      cnt          <= '0;
      rty          <= '0;
      pll_areset_q <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      fault_q      <= 1'b0;
      lock_loss_q  <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      rty          <= rty_nx;
      pll_areset_q <= (state_nx == RST_PLL) || (state_nx == FAULT);
      sys_rst_n_q  <= (state_nx == RUN);
      fault_q      <= (state_nx == FAULT);
      lock_loss_q  <= loss_nx;
    end
  end

  assign bus.pll_areset = pll_areset_q;
  assign bus.sys_rst_n  = sys_rst_n_q;
  assign bus.fault      = fault_q;
  assign bus.lock_loss  = lock_loss_q;

`ifdef PLL_SUP_STATUS_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  always_ff @(posedge clk) begin
    if (rst)                         loss_cnt <= '0;
    else if (loss_nx && ~&loss_cnt)  loss_cnt <= loss_cnt + 1'b1;
  end

  assign bus.lock_loss_cnt = loss_cnt;
  assign bus.state_o       = state;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: timestamp-based reference model checked every cycle,
// directed bring-up/fault/loss scenarios with literal timing pins, then random stimulus.
module tb_pll_lock_supervisor;
  localparam int PRC = 4, LSC = 16, TOC = 64, MR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_sup_if bus();

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC), .TIMEOUT_CYCLES(TOC), .MAX_RETRIES(MR)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;
  int rel = 0;

  // Model: phase id, cycle at which the phase began, failed attempts, lock history.
  int m_ph = 0, m_t_in = 0, m_fails = 0, m_cyc = 0, m_loss_cnt = 0;
  bit m_s1 = 0, m_s2 = 0, m_loss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, rel, act, exp);
    end
  endtask

  task automatic go(input int p);
    m_ph   = p;
    m_t_in = m_cyc + 1;
  endtask

  task automatic model_step(input bit r, input bit lk, input bit rs);
    bit ls;
    int el;
    ls     = m_s2;
    m_loss = 0;
    if (r) begin
      go(0);
      m_fails = 0; m_s1 = 0; m_s2 = 0; m_loss_cnt = 0;
    end else begin
      el = m_cyc - m_t_in + 1;
      if (rs) begin
        go(0);
        m_fails = 0;
      end else begin
        case (m_ph)
          0: if (el >= PRC) go(1);
          1: if (ls) go(2);
             else if (el >= TOC) begin
               if (m_fails < MR) begin m_fails++; go(0); end
               else go(4);
             end
          2: if (!ls) go(1);
             else if (el >= LSC) begin m_fails = 0; go(3); end
          3: if (!ls) begin
               m_loss = 1;
               if (m_loss_cnt < 255) m_loss_cnt++;
               go(0);
             end
          default: ;
        endcase
      end
      m_s2 = m_s1;
      m_s1 = lk;
    end
    m_cyc++;
  endtask

  task automatic tick(input bit r, input bit lk, input bit rs);
    rst        = r;
    bus.locked = lk;
    bus.restart = rs;
    @(posedge clk);
    model_step(r, lk, rs);
    @(negedge clk);
    rel = r ? 0 : rel + 1;
    chk("pll_areset", int'(bus.pll_areset), int'(m_ph == 0 || m_ph == 4));
    chk("sys_rst_n",  int'(bus.sys_rst_n),  int'(m_ph == 3));
    chk("fault",      int'(bus.fault),      int'(m_ph == 4));
    chk("lock_loss",  int'(bus.lock_loss),  int'(m_loss));
`ifdef PLL_SUP_STATUS_EN
    chk("lock_loss_cnt", int'(bus.lock_loss_cnt), m_loss_cnt);
    chk("state_o",       int'(bus.state_o),       m_ph);
`endif
  endtask

  task automatic check_reset_values();
    chk("rst_pll_areset", int'(bus.pll_areset), 1);
    chk("rst_sys_rst_n",  int'(bus.sys_rst_n),  0);
    chk("rst_fault",      int'(bus.fault),      0);
    chk("rst_lock_loss",  int'(bus.lock_loss),  0);
  endtask

  // Reset with locked high, optionally glitch locked for one input cycle; returns release cycle.
  task automatic bringup(input int glitch, output int rise);
    rise = -1;
    tick(1, 1, 0);
    check_reset_values();
    for (int c = 0; c < 45; c++) begin
      tick(0, c != glitch, 0);
      if (rel <= PRC + 1) chk("areset_window", int'(bus.pll_areset), int'(rel < PRC));
      if (bus.sys_rst_n && rise < 0) rise = rel;
    end
  endtask

  initial begin
    int rise, d, p, np, fcyc;
    bus.locked  = 1'b1;
    bus.restart = 1'b0;

    // Clean bring-up: release at cycle 21.
    bringup(-1, rise);
    chk("rise_clean", rise, 21);

    // One-cycle glitch reaching STABLE at count 10 forces a full new window.
    bringup(13, rise);
    chk("rise_glitch", rise, 33);

    // Lock loss in RUN: single pulse 3 cycles after the drop, re-release 24 cycles after it.
    d = rel; p = -1; np = 0; rise = -1;
    for (int k = 0; k < 45; k++) begin
      tick(0, !(k < 5), 0);
      if (bus.lock_loss) begin
        np++;
        p = rel;
        chk("sys_rst_n_at_loss", int'(bus.sys_rst_n), 0);
      end
      if (p >= 0 && rel > p && bus.sys_rst_n && rise < 0) rise = rel;
    end
    chk("loss_pulses", np, 1);
    chk("loss_delay", p - d, 3);
    chk("relock_delay", rise - d, 24);

    // rst for one cycle while in RUN aborts to reset values, then a normal bring-up.
    bringup(-1, rise);
    chk("rise_after_rst", rise, 21);

    // No lock: FAULT after the fourth timeout, restart clears it.
    tick(1, 0, 0);
    fcyc = -1;
    for (int c = 0; c < 300; c++) begin
      tick(0, 0, 0);
      if (bus.fault && fcyc < 0) fcyc = rel;
    end
    chk("fault_cycle", fcyc, 272);
    tick(0, 0, 1);
    chk("fault_cleared", int'(bus.fault), 0);
    chk("areset_after_restart", int'(bus.pll_areset), 1);
    for (int c = 0; c < 6; c++) tick(0, 0, 0);

    // Restart coincident with the second timeout: retry count restarts from zero.
    tick(1, 0, 0);
    fcyc = -1;
    for (int c = 0; c < 450; c++) begin
      tick(0, 0, c == 135);
      if (bus.fault && fcyc < 0) fcyc = rel;
    end
    chk("fault_after_restart", fcyc, 408);

    // Random stimulus against the model.
    tick(1, 1, 0);
    for (int seg = 0; seg < 300; seg++) begin
      bit lk;
      int len;
      lk  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++)
        tick($urandom_range(0, 600) == 0, lk, $urandom_range(0, 150) == 0);
    end

`ifdef PLL_SUP_STATUS_EN
    tick(1, 1, 0);
    for (int n = 0; n < 300; n++) begin
      int guard;
      guard = 0;
      while (!bus.sys_rst_n && guard < 100) begin
        tick(0, 1, 0);
        guard++;
      end
      if (guard >= 100) chk("reach_run_timeout", guard, 0);
      for (int k = 0; k < 3; k++) tick(0, 0, 0);
    end
    for (int k = 0; k < 30; k++) tick(0, 1, 0);
    chk("loss_cnt_saturated", int'(bus.lock_loss_cnt), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 4: cycles pll_areset is held high per PLL reset attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 16: consecutive synchronized-lock cycles required before releasing system reset.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for lock per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts tolerated before FAULT.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 locked  input  1  PLL lock flag, asynchronous to clk.
REQ-008 restart  input  1  single-cycle request to re-run the full PLL bring-up.
REQ-009 pll_areset  output  1  PLL reset, active high.
REQ-010 sys_rst_n  output  1  system reset to downstream logic, active low.
REQ-011 fault  output  1  bring-up failed after MAX_RETRIES attempts.
REQ-012 lock_loss  output  1  one-cycle pulse when lock drops in RUN.

Function
REQ-013 SHALL synchronize locked through two flops into lock_s; all decisions SHALL use lock_s only.
REQ-014 SHALL implement states RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT; all outputs registered, updated on the same edge as the state.
REQ-015 RST_PLL: pll_areset=1, sys_rst_n=0; SHALL go to WAIT_LOCK after exactly PLL_RST_CYCLES cycles in state.
REQ-016 WAIT_LOCK: pll_areset=0, sys_rst_n=0; lock_s=1 -> STABLE next cycle; TIMEOUT_CYCLES cycles without lock_s -> retry.
REQ-017 Retry: retry count < MAX_RETRIES -> increment, go RST_PLL; retry count == MAX_RETRIES -> FAULT.
REQ-018 STABLE: lock_s must stay 1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN; any lock_s=0 -> WAIT_LOCK with timeout counter cleared, retry count unchanged.
REQ-019 RUN: sys_rst_n=1, pll_areset=0; retry count cleared on entry.
REQ-020 RUN with lock_s=0 -> RST_PLL; sys_rst_n=0 and lock_loss=1 on the same edge; lock_loss lasts exactly one cycle.
REQ-021 FAULT: pll_areset=1, sys_rst_n=0, fault=1; exit only via rst or restart.
REQ-022 restart in any state -> RST_PLL with all counters and retry count cleared and fault=0; sys_rst_n=0 next edge.
REQ-023 Priority: rst > restart > lock loss/timeout > normal progression.
REQ-024 Counters SHALL be sized $clog2(max(param)+1) bits and SHALL NOT wrap; each is cleared on every state entry.

Reset
REQ-025 On rst: state RST_PLL, pll_areset=1, sys_rst_n=0, fault=0, lock_loss=0, counters, retry count and sync flops 0.
REQ-026 The PLL_RST_CYCLES count SHALL begin on the first cycle with rst=0; rst asserted mid-operation SHALL abort immediately to the reset values.

Configuration
REQ-027 With PLL_SUP_STATUS_EN defined: add output lock_loss_cnt (8 bits), saturating at 255 and incremented on each lock_loss pulse, and output state_o (3 bits) exposing the current state; both cleared only by rst.
REQ-028 Without PLL_SUP_STATUS_EN: those ports and their registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package pll_sup_pkg SHALL hold the state encoding (enum: RST_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4), STATE_W=3 and LOSS_CNT_W=8.
REQ-030 The two-flop synchronizer SHALL be sub-module sync2 (1-bit, reset to 0), instantiated once.

Verification (defaults)
REQ-031 locked tied 1 from time 0, release rst -> pll_areset high on cycles 0-3; sys_rst_n rises at cycle 21; fault=0.
REQ-032 locked tied 0 -> three RST_PLL/WAIT_LOCK cycles of 4+64 cycles each, then FAULT on the fourth timeout: fault=1, pll_areset=1; restart pulse -> fault=0, pll_areset high for 4 cycles.
REQ-033 In RUN, drop locked for 5 cycles -> lock_loss pulses once, 2-3 cycles after the drop, sys_rst_n falls on the same edge; re-raise -> sys_rst_n returns high after 4 + re-lock + 16 cycles.
REQ-034 In STABLE, glitch locked low for 1 cycle at stable count 10 -> return to WAIT_LOCK, retry count unchanged, full 16-cycle stable window then required.
REQ-035 Assert rst for 1 cycle while in RUN, and separately restart coincident with a WAIT_LOCK timeout -> reset values / RST_PLL entry with retry count 0, respectively.
REQ-036 With PLL_SUP_STATUS_EN, force 300 lock losses -> lock_loss_cnt=255 and holds.
